// File: rtl/move_grant_responder.sv
// Responder for the player one-tile move request/grant handshake: bounds check plus map ROM lookup.
// Optional step cooldown after a granted move is built only when STEP_COOLDOWN_EN is defined.
module move_grant_responder #(
  parameter int MAP_W  = 20,
  parameter int MAP_H  = 15,
  parameter int ADDR_W = 9
`ifdef STEP_COOLDOWN_EN
  ,
  parameter int COOLDOWN = 2047
`endif
) (
  input  logic              clk_13,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_dir,
  input  logic [3:0]        cur_row,
  input  logic [4:0]        cur_col,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_grant,
  output logic [3:0]        rsp_row,
  output logic [4:0]        rsp_col,
  output logic              door_hit,
  output logic              map_rd,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [1:0]        map_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    EVAL  = 3'd3,
    RESP  = 3'd4
`ifdef STEP_COOLDOWN_EN
    ,
    COOL  = 3'd5
`endif
  } state_t;

  state_t state_r;
  state_t next_s;

  logic [2:0] dir_r;
  logic [3:0] row_r;
  logic [4:0] col_r;
  logic [3:0] tgt_row_r;
  logic [4:0] tgt_col_r;

  logic [4:0]        tgt_row_s;
  logic [5:0]        tgt_col_s;
  logic              is_stop_s;
  logic              bad_dir_s;
  logic              oob_s;
  logic              fast_s;
  logic [ADDR_W-1:0] addr_s;

  logic              req_ready_n;
  logic              rsp_valid_n;
  logic              rsp_grant_n;
  logic [3:0]        rsp_row_n;
  logic [4:0]        rsp_col_n;
  logic              door_hit_n;
  logic              map_rd_n;
  logic [ADDR_W-1:0] map_addr_n;

`ifdef STEP_COOLDOWN_EN
  localparam int CNT_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
`endif

  // Target tile, one bit wider so that stepping off row/col 0 wraps to an out-of-range value.
  always_comb begin
    tgt_row_s = {1'b0, row_r};
    tgt_col_s = {1'b0, col_r};
    case (dir_r)
      3'd1:    tgt_row_s = {1'b0, row_r} + 5'd1;
      3'd2:    tgt_row_s = {1'b0, row_r} - 5'd1;
      3'd3:    tgt_col_s = {1'b0, col_r} - 6'd1;
      3'd4:    tgt_col_s = {1'b0, col_r} + 6'd1;
      default: begin
        tgt_row_s = {1'b0, row_r};
        tgt_col_s = {1'b0, col_r};
      end
    endcase
  end

  assign is_stop_s = (dir_r == 3'd0);
  assign bad_dir_s = (dir_r > 3'd4);
  assign oob_s     = (tgt_row_s >= 5'(MAP_H)) || (tgt_col_s >= 6'(MAP_W));
  assign fast_s    = is_stop_s || bad_dir_s || oob_s;
  assign addr_s    = ADDR_W'(tgt_row_s[3:0]) * ADDR_W'(MAP_W) + ADDR_W'(tgt_col_s[4:0]);

  // State register.
  always_ff @(posedge clk_13 or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          next_s = CHECK;
        end else begin
          next_s = IDLE;
        end
      end
      CHECK: begin
        if (fast_s) begin
          next_s = RESP;
        end else begin
          next_s = RD;
        end
      end
      RD:   next_s = EVAL;
      EVAL: next_s = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
`ifdef STEP_COOLDOWN_EN
          next_s = rsp_grant ? COOL : IDLE;
`else
          next_s = IDLE;
`endif
        end else begin
          next_s = RESP;
        end
      end
`ifdef STEP_COOLDOWN_EN
      COOL: begin
        if (cnt_r == '0) begin
          next_s = IDLE;
        end else begin
          next_s = COOL;
        end
      end
`endif
      default: next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; the fast path raises rsp_valid one cycle after entering RESP.
  always_comb begin
    req_ready_n = (next_s == IDLE);
    rsp_valid_n = rsp_valid;
    rsp_grant_n = rsp_grant;
    rsp_row_n   = rsp_row;
    rsp_col_n   = rsp_col;
    door_hit_n  = door_hit;
    map_rd_n    = 1'b0;
    map_addr_n  = map_addr;
    case (state_r)
      CHECK: begin
        if (fast_s) begin
          rsp_grant_n = is_stop_s;
          rsp_row_n   = row_r;
          rsp_col_n   = col_r;
          door_hit_n  = 1'b0;
        end else begin
          map_rd_n   = 1'b1;
          map_addr_n = addr_s;
        end
      end
      EVAL: begin
        case (map_data)
          2'd0: begin
            rsp_grant_n = 1'b1;
            door_hit_n  = 1'b0;
          end
          2'd3: begin
            rsp_grant_n = 1'b1;
            door_hit_n  = 1'b1;
          end
          default: begin
            rsp_grant_n = 1'b0;
            door_hit_n  = 1'b0;
          end
        endcase
        rsp_row_n   = rsp_grant_n ? tgt_row_r : row_r;
        rsp_col_n   = rsp_grant_n ? tgt_col_r : col_r;
        rsp_valid_n = 1'b1;
      end
      RESP: begin
        if (!rsp_valid) begin
          rsp_valid_n = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          door_hit_n  = 1'b0;
        end else begin
          rsp_valid_n = rsp_valid;
        end
      end
      default: rsp_valid_n = rsp_valid;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk_13 or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_grant <= 1'b0;
      rsp_row   <= 4'd0;
      rsp_col   <= 5'd0;
      door_hit  <= 1'b0;
      map_rd    <= 1'b0;
      map_addr  <= '0;
    end else begin
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_grant <= rsp_grant_n;
      rsp_row   <= rsp_row_n;
      rsp_col   <= rsp_col_n;
      door_hit  <= door_hit_n;
      map_rd    <= map_rd_n;
      map_addr  <= map_addr_n;
    end
  end

  // Request capture at accept and target capture for the ROM path.
  always_ff @(posedge clk_13 or posedge rst) begin
    if (rst) begin
      dir_r     <= 3'd0;
      row_r     <= 4'd0;
      col_r     <= 5'd0;
      tgt_row_r <= 4'd0;
      tgt_col_r <= 5'd0;
    end else begin
      if (state_r == IDLE && req_valid) begin
        dir_r <= req_dir;
        row_r <= cur_row;
        col_r <= cur_col;
      end
      if (state_r == CHECK) begin
        tgt_row_r <= tgt_row_s[3:0];
        tgt_col_r <= tgt_col_s[4:0];
      end
    end
  end

`ifdef STEP_COOLDOWN_EN
  // Cooldown counter: loaded on a granted handshake, counts down while in COOL.
  always_comb begin
    cnt_n = cnt_r;
    if (state_r == RESP && rsp_valid && rsp_ready && rsp_grant) begin
      cnt_n = CNT_W'(COOLDOWN);
    end else if (state_r == COOL && cnt_r != '0) begin
      cnt_n = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_n = cnt_r;
    end
  end

  // Cooldown counter register.
  always_ff @(posedge clk_13 or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_move_grant_responder.sv
// Directed self-checking bench for move_grant_responder with a registered map ROM model.
// The cooldown vectors are compiled only when STEP_COOLDOWN_EN is defined.
module tb_move_grant_responder;

  localparam int ADDR_W = 9;

  logic              clk_13;
  logic              rst;
  logic              req_valid;
  logic [2:0]        req_dir;
  logic [3:0]        cur_row;
  logic [4:0]        cur_col;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_grant;
  logic [3:0]        rsp_row;
  logic [4:0]        rsp_col;
  logic              door_hit;
  logic              map_rd;
  logic [ADDR_W-1:0] map_addr;
  logic [1:0]        map_data;

  logic [1:0] rom [0:511];
  int vectors;
  int miscompares;

  move_grant_responder #(
    .MAP_W(20),
    .MAP_H(15),
    .ADDR_W(ADDR_W)
`ifdef STEP_COOLDOWN_EN
    ,
    .COOLDOWN(4)
`endif
  ) dut (
    .clk_13   (clk_13),
    .rst      (rst),
    .req_valid(req_valid),
    .req_dir  (req_dir),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_grant(rsp_grant),
    .rsp_row  (rsp_row),
    .rsp_col  (rsp_col),
    .door_hit (door_hit),
    .map_rd   (map_rd),
    .map_addr (map_addr),
    .map_data (map_data)
  );

  initial clk_13 = 1'b0;
  always #5 clk_13 = ~clk_13;

  // Map ROM model: data valid one cycle after the read enable is sampled.
  always @(posedge clk_13) begin
    if (map_rd) map_data <= rom[map_addr];
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_13);
    #1;
  endtask

  // Presents a request in IDLE and returns just after the accept edge E0.
  task automatic issue(input logic [2:0] d, input logic [3:0] r, input logic [4:0] c);
    check_value("ready_before_req", 32'(req_ready), 32'd1);
    req_dir   = d;
    cur_row   = r;
    cur_col   = c;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_value("ready_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic expect_rsp(input string tag, input logic g, input logic [3:0] r,
                            input logic [4:0] c, input logic door);
    check_value({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_value({tag, "_grant"}, 32'(rsp_grant), 32'(g));
    check_value({tag, "_row"},   32'(rsp_row),   32'(r));
    check_value({tag, "_col"},   32'(rsp_col),   32'(c));
    check_value({tag, "_door"},  32'(door_hit),  32'(door));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 512; i++) rom[i] = 2'd0;
    rom[125] = 2'd0;  // (6,5) floor
    rom[59]  = 2'd3;  // (2,19) door
    rom[84]  = 2'd1;  // (4,4) wall
    map_data  = 2'd0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_dir   = 3'd0;
    cur_row   = 4'd0;
    cur_col   = 5'd0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check_value("rst_req_ready", 32'(req_ready), 32'd1);
    check_value("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("rst_rsp_grant", 32'(rsp_grant), 32'd0);
    check_value("rst_door_hit",  32'(door_hit),  32'd0);
    check_value("rst_map_rd",    32'(map_rd),    32'd0);
    check_value("rst_rsp_row",   32'(rsp_row),   32'd0);
    check_value("rst_rsp_col",   32'(rsp_col),   32'd0);
    check_value("rst_map_addr",  32'(map_addr),  32'd0);

    // (5,5) DOWN onto floor: ROM path.
    issue(3'd1, 4'd5, 5'd5);
    tick();
    check_value("down_map_rd_e1", 32'(map_rd), 32'd1);
    check_value("down_map_addr",  32'(map_addr), 32'd125);
    tick();
    check_value("down_map_rd_e2", 32'(map_rd), 32'd0);
    check_value("down_valid_e2",  32'(rsp_valid), 32'd0);
    tick();
    expect_rsp("down_e3", 1'b1, 4'd6, 5'd5, 1'b0);
    check_value("down_ready_resp", 32'(req_ready), 32'd0);
    tick();
    check_value("down_valid_done", 32'(rsp_valid), 32'd0);
    check_value("down_ready_done", 32'(req_ready), 32'd1);

    // (0,3) UP: off the top edge.
    issue(3'd2, 4'd0, 5'd3);
    tick();
    check_value("up_map_rd_e1", 32'(map_rd), 32'd0);
    check_value("up_valid_e1",  32'(rsp_valid), 32'd0);
    tick();
    check_value("up_map_rd_e2", 32'(map_rd), 32'd0);
    expect_rsp("up_e2", 1'b0, 4'd0, 5'd3, 1'b0);
    tick();
    check_value("up_valid_done", 32'(rsp_valid), 32'd0);

    // (2,19) RIGHT: off the right edge.
    issue(3'd4, 4'd2, 5'd19);
    tick();
    check_value("right_oob_map_rd", 32'(map_rd), 32'd0);
    tick();
    expect_rsp("right_oob", 1'b0, 4'd2, 5'd19, 1'b0);
    tick();

    // (2,18) RIGHT onto a door.
    issue(3'd4, 4'd2, 5'd18);
    tick();
    check_value("door_map_addr", 32'(map_addr), 32'd59);
    tick();
    tick();
    expect_rsp("door", 1'b1, 4'd2, 5'd19, 1'b1);
    tick();
    check_value("door_cleared", 32'(door_hit), 32'd0);
    check_value("door_valid_done", 32'(rsp_valid), 32'd0);

    // (14,7) DOWN: off the bottom edge.
    issue(3'd1, 4'd14, 5'd7);
    tick();
    tick();
    expect_rsp("bottom_oob", 1'b0, 4'd14, 5'd7, 1'b0);
    tick();

    // STOP grants in place, no ROM read.
    issue(3'd0, 4'd7, 5'd7);
    tick();
    check_value("stop_map_rd", 32'(map_rd), 32'd0);
    tick();
    expect_rsp("stop", 1'b1, 4'd7, 5'd7, 1'b0);
    tick();

    // Invalid direction code 6 is denied.
    issue(3'd6, 4'd7, 5'd7);
    tick();
    tick();
    expect_rsp("bad_dir", 1'b0, 4'd7, 5'd7, 1'b0);
    tick();

    // (4,5) LEFT into a wall with rsp_ready held low for 10 cycles.
    rsp_ready = 1'b0;
    issue(3'd3, 4'd4, 5'd5);
    tick();
    check_value("wall_map_addr", 32'(map_addr), 32'd84);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      expect_rsp("wall_hold", 1'b0, 4'd4, 5'd5, 1'b0);
      check_value("wall_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check_value("wall_valid_done", 32'(rsp_valid), 32'd0);
    check_value("wall_ready_done", 32'(req_ready), 32'd1);

    // Reset while the ROM read is in flight drops the request.
    issue(3'd1, 4'd5, 5'd5);
    tick();
    check_value("rstrd_map_rd", 32'(map_rd), 32'd1);
    rst = 1'b1;
    #1;
    check_value("rstrd_map_rd_clr", 32'(map_rd), 32'd0);
    check_value("rstrd_valid", 32'(rsp_valid), 32'd0);
    check_value("rstrd_ready", 32'(req_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("rstrd_no_rsp", 32'(rsp_valid), 32'd0);
      check_value("rstrd_idle_ready", 32'(req_ready), 32'd1);
      check_value("rstrd_no_rd", 32'(map_rd), 32'd0);
    end

`ifdef STEP_COOLDOWN_EN
    // Granted handshake: req_ready low exactly 5 cycles after the handshake edge.
    issue(3'd0, 4'd3, 5'd3);
    tick();
    tick();
    expect_rsp("cool_stop", 1'b1, 4'd3, 5'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("cool_ready_low", 32'(req_ready), 32'd0);
    end
    tick();
    check_value("cool_ready_back", 32'(req_ready), 32'd1);

    // Denied handshake skips the cooldown.
    issue(3'd2, 4'd0, 5'd3);
    tick();
    tick();
    expect_rsp("cool_deny", 1'b0, 4'd0, 5'd3, 1'b0);
    tick();
    check_value("deny_ready_next", 32'(req_ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
